axi4_lite_master_ctrl: RTL and testbench



---
 rtl/axi4_lite_master_ctrl.sv | 172 +++++++++++++++++
 tb/tb_axi4_lite_master_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master_ctrl.sv
// Single-outstanding AXI4-Lite master: turns one local command into an AXI read or
// write transaction and returns one response beat per command.
module axi4_lite_master_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;

  state_t                state_q, state_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                  arvalid_q, arvalid_d, rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          rsp_write_d = cmd_write;
          if (cmd_write) begin
            awaddr_d    = cmd_addr;
            wdata_d     = cmd_wdata;
            wstrb_d     = cmd_wstrb;
            awvalid_d   = 1'b1;
            wvalid_d    = 1'b1;
            rsp_rdata_d = '0;
            state_d     = WR_ADDR_DATA;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR_ADDR_DATA: begin
        // AW and W retire independently; move on once both have handshaken
        if (awready) awvalid_d = 1'b0;
        if (wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          rsp_resp_d = bresp;
          bready_d   = 1'b0;
          state_d    = RESP;
        end
      end
      RD_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rvalid) begin
          rsp_rdata_d = rdata;
          rsp_resp_d  = rresp;
          rready_d    = 1'b0;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign awaddr    = awaddr_q;
  assign awprot    = 1'b0;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign araddr    = araddr_q;
  assign arprot    = 1'b0;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;

endmodule

// File: tb/tb_axi4_lite_master_ctrl.sv
// Directed bench for axi4_lite_master_ctrl against a small 8-word AXI4-Lite slave
// model with programmable per-channel wait states and response code.
module tb_axi4_lite_master_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [2:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_write, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [2:0]  awaddr, araddr;
  logic        awprot, awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arprot, arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 aclk = ~aclk;

  axi4_lite_master_ctrl dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .busy(busy),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  // ---------------- slave model ----------------
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  resp_code = 2'b00;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic        aw_got, w_got, b_pend, r_pend;
  logic [2:0]  aw_a, wr_a;
  logic [31:0] w_d, wr_d, r_d;
  logic [3:0]  w_s, wr_s;
  logic [31:0] mem [0:7];

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid && (w_cnt >= w_dly);
  assign arready = arvalid && (ar_cnt >= ar_dly);
  assign bvalid  = b_pend && (b_cnt >= b_dly);
  assign rvalid  = r_pend && (r_cnt >= r_dly);
  assign bresp   = resp_code;
  assign rresp   = resp_code;
  assign rdata   = r_d;
  assign wr_a    = aw_got ? aw_a : awaddr;
  assign wr_d    = w_got ? w_d : wdata;
  assign wr_s    = w_got ? w_s : wstrb;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0;
      aw_a <= '0; w_d <= '0; w_s <= '0; r_d <= '0;
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (awvalid && awready) begin aw_got <= 1; aw_a <= awaddr; end
      if (wvalid && wready) begin w_got <= 1; w_d <= wdata; w_s <= wstrb; end
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
        for (int b = 0; b < 4; b++)
          if (wr_s[b]) mem[wr_a][8*b +: 8] <= wr_d[8*b +: 8];
        aw_got <= 0; w_got <= 0; b_pend <= 1; b_cnt <= 0;
      end else if (b_pend && !bvalid) b_cnt <= b_cnt + 1;
      if (bvalid && bready) b_pend <= 0;
      if (r_pend && !rvalid) r_cnt <= r_cnt + 1;
      if (rvalid && rready) r_pend <= 0;
      if (arvalid && arready) begin r_pend <= 1; r_cnt <= 0; r_d <= mem[araddr]; end
    end
  end

  // ---------------- monitors ----------------
  int cyc = 0, n_acc = 0, n_bhs = 0, n_rsp = 0, n_viol = 0;
  logic        aw_p = 0, w_p = 0, ar_p = 0;
  logic [2:0]  awaddr_p, araddr_p;
  logic [31:0] wdata_p;
  logic [3:0]  wstrb_p;

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready && aresetn) n_acc <= n_acc + 1;
    if (bvalid && bready) n_bhs <= n_bhs + 1;
    if (rsp_valid) n_rsp <= n_rsp + 1;
    if (!aresetn) begin
      aw_p <= 0; w_p <= 0; ar_p <= 0;
    end else begin
      // a valid left waiting last cycle must still be up with an unchanged payload
      if ((aw_p && (!awvalid || awaddr != awaddr_p)) ||
          (w_p && (!wvalid || wdata != wdata_p || wstrb != wstrb_p)) ||
          (ar_p && (!arvalid || araddr != araddr_p)))
        n_viol <= n_viol + 1;
      aw_p <= awvalid && !awready; awaddr_p <= awaddr;
      w_p  <= wvalid && !wready;   wdata_p  <= wdata; wstrb_p <= wstrb;
      ar_p <= arvalid && !arready; araddr_p <= araddr;
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0, n_fail = 0;
  int acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [2:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    int k = 0;
    @(negedge aclk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && k < 50) begin k++; @(negedge aclk); end
    chk("cmd_accept", cmd_ready, 1);
    acc = cyc;
    @(posedge aclk);
    #1 cmd_valid = 0;
  endtask

  // latency counts the acceptance cycle through the rsp_valid cycle inclusive
  task automatic wait_rsp(output logic [31:0] rd, output logic [1:0] rr, output logic rw,
                          output int lat, output int bad);
    int k = 0;
    bad = 0;
    @(negedge aclk);
    while (!rsp_valid && k < 60) begin
      if (cmd_ready !== 1'b0 || busy !== 1'b1) bad++;
      k++;
      @(negedge aclk);
    end
    chk("rsp_seen", rsp_valid, 1);
    rd = rsp_rdata; rr = rsp_resp; rw = rsp_write; lat = cyc - acc + 1;
    @(negedge aclk);
    chk("rsp_pulse", rsp_valid, 0);
  endtask

  logic [31:0] rd;
  logic [1:0]  rr;
  logic        rw;
  int          lat, bad, b0, r0, k;

  initial begin
    aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    repeat (3) @(negedge aclk);
    chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    aresetn = 1;
    @(negedge aclk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);

    // zero-wait write
    b0 = n_bhs;
    send_cmd(1, 3'd1, 32'd100, 4'hF);
    @(negedge aclk);
    chk("wr1_aw_w_together", {awvalid, wvalid}, 2'b11);
    chk("wr1_awaddr", awaddr, 1);
    chk("wr1_busy", {busy, cmd_ready}, 2'b10);
    wait_rsp(rd, rr, rw, lat, bad);
    chk("wr1_lat", lat, 4);
    chk("wr1_rsp_write", rw, 1);
    chk("wr1_rsp_resp", rr, 0);
    chk("wr1_rsp_rdata", rd, 0);
    chk("wr1_b_hs", n_bhs - b0, 1);

    // W accepted three cycles before AW
    aw_dly = 3; b0 = n_bhs;
    send_cmd(1, 3'd2, 32'd200, 4'hF);
    @(negedge aclk);
    chk("wr2_both_up", {awvalid, wvalid}, 2'b11);
    @(negedge aclk);
    chk("wr2_w_first", {awvalid, wvalid}, 2'b10);
    wait_rsp(rd, rr, rw, lat, bad);
    chk("wr2_b_hs", n_bhs - b0, 1);
    chk("wr2_rsp_write", rw, 1);
    aw_dly = 0;

    // zero-wait read
    send_cmd(0, 3'd1, 32'h0, 4'h0);
    @(negedge aclk);
    chk("rd1_arvalid", {arvalid, araddr}, {1'b1, 3'd1});
    wait_rsp(rd, rr, rw, lat, bad);
    chk("rd1_lat", lat, 4);
    chk("rd1_rdata", rd, 100);
    chk("rd1_rsp_write", rw, 0);
    chk("rd1_rsp_resp", rr, 0);

    // stalled read of register 2
    ar_dly = 5; r_dly = 2; r0 = n_rsp;
    send_cmd(0, 3'd2, 32'h0, 4'h0);
    wait_rsp(rd, rr, rw, lat, bad);
    chk("rd2_rdata", rd, 200);
    chk("rd2_lat", lat, 11);
    chk("rd2_busy_hold", bad, 0);
    chk("rd2_one_rsp", n_rsp - r0, 1);
    ar_dly = 0; r_dly = 0;

    // partial strobe onto a zeroed word
    send_cmd(1, 3'd4, 32'hAABBCCDD, 4'b0101);
    wait_rsp(rd, rr, rw, lat, bad);
    send_cmd(0, 3'd4, 32'h0, 4'h0);
    wait_rsp(rd, rr, rw, lat, bad);
    chk("strb_rdata", rd, 32'h00BB00DD);

    // error response is passed through
    resp_code = 2'b10;
    send_cmd(1, 3'd7, 32'h7, 4'hF);
    wait_rsp(rd, rr, rw, lat, bad);
    chk("slverr_bresp", rr, 2'b10);
    send_cmd(0, 3'd7, 32'h0, 4'h0);
    wait_rsp(rd, rr, rw, lat, bad);
    chk("slverr_rresp", rr, 2'b10);
    resp_code = 2'b00;

    // back-to-back with cmd_valid held high
    r0 = n_acc;
    send_cmd(1, 3'd3, 32'hDEADBEEF, 4'hF);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 3'd3;
    k = 0;
    @(negedge aclk);
    while (!rsp_valid && k < 50) begin k++; @(negedge aclk); end
    chk("b2b_wr_rsp", {rsp_valid, rsp_write}, 2'b11);
    chk("b2b_held_off", n_acc - r0, 1);
    @(negedge aclk);
    chk("b2b_idle_ready", cmd_ready, 1);
    acc = cyc;
    @(posedge aclk);
    #1 cmd_valid = 0;
    wait_rsp(rd, rr, rw, lat, bad);
    chk("b2b_rd_data", rd, 32'hDEADBEEF);
    chk("b2b_rd_lat", lat, 4);
    chk("b2b_accepts", n_acc - r0, 2);

    // reset while waiting in WR_RESP
    b_dly = 10;
    send_cmd(1, 3'd5, 32'h55, 4'hF);
    k = 0;
    @(negedge aclk);
    while (!bready && k < 20) begin k++; @(negedge aclk); end
    chk("rst_mid_bready_up", bready, 1);
    @(negedge aclk);
    r0 = n_rsp;
    aresetn = 0;
    #1;
    chk("rst_mid_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
    repeat (2) @(negedge aclk);
    b_dly = 0;
    aresetn = 1;
    @(negedge aclk);
    chk("rst_mid_ready", {cmd_ready, busy}, 2'b10);
    repeat (3) @(negedge aclk);
    chk("rst_mid_no_rsp", n_rsp - r0, 0);

    // recovery after the abort
    send_cmd(1, 3'd6, 32'h1234, 4'hF);
    wait_rsp(rd, rr, rw, lat, bad);
    send_cmd(0, 3'd6, 32'h0, 4'h0);
    wait_rsp(rd, rr, rw, lat, bad);
    chk("recover_rdata", rd, 32'h1234);

    chk("axi_stable", n_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
